// File: rtl/conv1d_reg_file_pkg.sv
// Shared types and constants for the conv1d register slave: word map, bit positions,
// FSM state encodings and the default register bus payloads.
package conv1d_reg_file_pkg;

    localparam int unsigned DefaultAddrWidth  = 32;
    localparam int unsigned DefaultDataWidth  = 32;
    localparam int unsigned DefaultNumCfgRegs = 8;

    localparam int unsigned CtrlWordIdx   = 0;
    localparam int unsigned StatusWordIdx = 1;
    localparam int unsigned CfgBaseIdx    = 2;

    localparam int unsigned CtrlStartBit = 0;
    localparam int unsigned CtrlClearBit = 1;
    localparam int unsigned CtrlIrqEnBit = 2;

    localparam int unsigned StatBusyBit = 0;
    localparam int unsigned StatDoneBit = 1;
    localparam int unsigned StatErrBit  = 2;

    typedef enum logic {
        ACC_IDLE = 1'b0,
        ACC_RESP = 1'b1
    } acc_state_e;

    typedef enum logic {
        J_IDLE = 1'b0,
        J_RUN  = 1'b1
    } job_state_e;

    typedef struct packed {
        logic [DefaultAddrWidth-1:0]   addr;
        logic                          write;
        logic [DefaultDataWidth-1:0]   wdata;
        logic [DefaultDataWidth/8-1:0] wstrb;
        logic                          valid;
    } reg_req_t;

    typedef struct packed {
        logic                        error;
        logic                        ready;
        logic [DefaultDataWidth-1:0] rdata;
    } reg_resp_t;

endpackage

// File: rtl/conv1d_job_ctrl.sv
// Job sequencer for the conv1d datapath: issues the start pulse, tracks busy and
// keeps the sticky DONE/ERR flags with their clear paths.
module conv1d_job_ctrl
    import conv1d_reg_file_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic clear_i,
    input  logic done_w1c_i,
    input  logic err_w1c_i,
    input  logic done_i,
    input  logic err_i,
    output logic busy_o,
    output logic start_o,
    output logic done_o,
    output logic err_o
);

    job_state_e state_q, state_d;
    logic       start_q, start_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= J_IDLE;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Hardware set events take priority over software clears.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        done_d  = done_q & ~done_w1c_i & ~clear_i;
        err_d   = (err_q & ~err_w1c_i & ~clear_i) | err_i;
        unique case (state_q)
            J_IDLE: begin
                if (start_i) begin
                    state_d = J_RUN;
                    start_d = 1'b1;
                end
            end
            J_RUN: begin
                if (done_i) begin
                    state_d = J_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = J_IDLE;
        endcase
    end

    assign busy_o  = (state_q == J_RUN);
    assign start_o = start_q;
    assign done_o  = done_q;
    assign err_o   = err_q;

endmodule

// File: rtl/conv1d_reg_file.sv
// Register slave for the conv1d accelerator: CTRL/STATUS/CFG decode, CFG storage and a
// registered one-cycle response. Optional completion interrupt via CONV1D_REG_IRQ_EN.
module conv1d_reg_file
    import conv1d_reg_file_pkg::*;
#(
    parameter int unsigned            AddrWidth  = DefaultAddrWidth,
    parameter int unsigned            DataWidth  = DefaultDataWidth,
    parameter int unsigned            NumCfgRegs = DefaultNumCfgRegs,
    parameter logic [AddrWidth-1:0]   BaseAddr   = '0,
    parameter type                    reg_req_t  = conv1d_reg_file_pkg::reg_req_t,
    parameter type                    reg_rsp_t  = conv1d_reg_file_pkg::reg_resp_t
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  reg_req_t                         reg_req_i,
    output reg_rsp_t                         reg_rsp_o,
    output logic                             start_o,
    output logic                             busy_o,
    input  logic                             done_i,
    input  logic                             err_i,
    output logic [NumCfgRegs*DataWidth-1:0]  cfg_o,
    output logic                             irq_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned ByteSelW  = $clog2(StrbWidth);
    localparam int unsigned MapWords  = CfgBaseIdx + NumCfgRegs;

    if ($bits(reg_req_i.addr) != AddrWidth) begin : g_chk_addr
        $error("reg_req_t.addr width does not match AddrWidth");
    end
    if ($bits(reg_req_i.wdata) != DataWidth) begin : g_chk_wdata
        $error("reg_req_t.wdata width does not match DataWidth");
    end
    if ($bits(reg_req_i.wstrb) != StrbWidth) begin : g_chk_wstrb
        $error("reg_req_t.wstrb width does not match DataWidth/8");
    end
    if (NumCfgRegs < 1 || NumCfgRegs > 64) begin : g_chk_ncfg
        $error("NumCfgRegs must be in 1..64");
    end

    acc_state_e                                acc_state_q, acc_state_d;
    reg_rsp_t                                  rsp_q, rsp_d;
    logic [NumCfgRegs-1:0][DataWidth-1:0]      cfg_q, cfg_d;
    logic                                      irq_en_c;

    logic [AddrWidth-1:0] offset_c;
    logic [AddrWidth-1:0] word_c;
    logic                 addr_ok_c;
    logic [DataWidth-1:0] rdata_c;

    logic job_start_c, job_clear_c, done_w1c_c, err_w1c_c;
    logic busy_c, done_c, err_c;

    assign offset_c  = reg_req_i.addr - BaseAddr;
    assign word_c    = offset_c >> ByteSelW;
    assign addr_ok_c = (reg_req_i.addr >= BaseAddr)
                     && (offset_c[ByteSelW-1:0] == '0)
                     && (word_c < AddrWidth'(MapWords));

`ifdef CONV1D_REG_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_q & done_c;
        end
    end

    assign irq_en_c = irq_en_q;
    assign irq_o    = irq_q;
`else
    assign irq_en_c = 1'b0;
    assign irq_o    = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_state_q <= ACC_IDLE;
            rsp_q       <= '0;
            cfg_q       <= '0;
        end else begin
            acc_state_q <= acc_state_d;
            rsp_q       <= rsp_d;
            cfg_q       <= cfg_d;
        end
    end

    // Read mux, evaluated against pre-edge register state.
    always_comb begin
        rdata_c = '0;
        if (word_c == AddrWidth'(CtrlWordIdx)) begin
            rdata_c[CtrlIrqEnBit] = irq_en_c;
        end else if (word_c == AddrWidth'(StatusWordIdx)) begin
            rdata_c[StatBusyBit] = busy_c;
            rdata_c[StatDoneBit] = done_c;
            rdata_c[StatErrBit]  = err_c;
        end else begin
            for (int unsigned i = 0; i < NumCfgRegs; i++) begin
                if (word_c == AddrWidth'(CfgBaseIdx + i)) begin
                    rdata_c = cfg_q[i];
                end
            end
        end
    end

    // Bus FSM: one access executes per IDLE->RESP transition.
    always_comb begin
        acc_state_d = acc_state_q;
        rsp_d       = '0;
        cfg_d       = cfg_q;
        job_start_c = 1'b0;
        job_clear_c = 1'b0;
        done_w1c_c  = 1'b0;
        err_w1c_c   = 1'b0;
`ifdef CONV1D_REG_IRQ_EN
        irq_en_d    = irq_en_q;
`endif
        unique case (acc_state_q)
            ACC_IDLE: begin
                if (reg_req_i.valid) begin
                    acc_state_d = ACC_RESP;
                    rsp_d.ready = 1'b1;
                    if (!addr_ok_c) begin
                        rsp_d.error = 1'b1;
                    end else if (!reg_req_i.write) begin
                        rsp_d.rdata = rdata_c;
                    end else if (word_c == AddrWidth'(CtrlWordIdx)) begin
                        if (busy_c && reg_req_i.wstrb[0] &&
                            (reg_req_i.wdata[CtrlStartBit] || reg_req_i.wdata[CtrlClearBit])) begin
                            rsp_d.error = 1'b1;
                        end else if (reg_req_i.wstrb[0]) begin
                            job_start_c = reg_req_i.wdata[CtrlStartBit];
                            job_clear_c = reg_req_i.wdata[CtrlClearBit];
`ifdef CONV1D_REG_IRQ_EN
                            irq_en_d    = reg_req_i.wdata[CtrlIrqEnBit];
`endif
                            if (reg_req_i.wdata[CtrlClearBit]) begin
                                cfg_d = '0;
                            end
                        end
                    end else if (word_c == AddrWidth'(StatusWordIdx)) begin
                        if (reg_req_i.wstrb[0]) begin
                            done_w1c_c = reg_req_i.wdata[StatDoneBit];
                            err_w1c_c  = reg_req_i.wdata[StatErrBit];
                        end
                    end else if (busy_c) begin
                        rsp_d.error = 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < NumCfgRegs; i++) begin
                            if (word_c == AddrWidth'(CfgBaseIdx + i)) begin
                                for (int unsigned b = 0; b < StrbWidth; b++) begin
                                    if (reg_req_i.wstrb[b]) begin
                                        cfg_d[i][b*8 +: 8] = reg_req_i.wdata[b*8 +: 8];
                                    end
                                end
                            end
                        end
                    end
                end
            end
            ACC_RESP: acc_state_d = ACC_IDLE;
            default:  acc_state_d = ACC_IDLE;
        endcase
    end

    conv1d_job_ctrl u_job_ctrl (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (job_start_c),
        .clear_i    (job_clear_c),
        .done_w1c_i (done_w1c_c),
        .err_w1c_i  (err_w1c_c),
        .done_i     (done_i),
        .err_i      (err_i),
        .busy_o     (busy_c),
        .start_o    (start_o),
        .done_o     (done_c),
        .err_o      (err_c)
    );

    assign busy_o    = busy_c;
    assign reg_rsp_o = rsp_q;
    assign cfg_o     = cfg_q;

endmodule

// File: tb/tb_conv1d_reg_file.sv
// Directed self-checking bench for conv1d_reg_file; irq checks follow CONV1D_REG_IRQ_EN.
module tb_conv1d_reg_file;
    import conv1d_reg_file_pkg::*;

    logic                clk;
    logic                rst_n;
    reg_req_t            req;
    reg_resp_t           rsp;
    logic                start_o, busy_o, done_i, err_i, irq_o;
    logic [8*32-1:0]     cfg_o;

    int n_cmp;
    int n_err;
    int last_lat;

    logic [31:0] rd;
    logic        er;
    logic [31:0] cfg3_exp;

    conv1d_reg_file dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .reg_req_i (req),
        .reg_rsp_o (rsp),
        .start_o   (start_o),
        .busy_o    (busy_o),
        .done_i    (done_i),
        .err_i     (err_i),
        .cfg_o     (cfg_o),
        .irq_o     (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One access: idle cycle, raise valid, wait bounded for ready. Optional done_i in the execute cycle.
    task automatic bus_acc(input string tag, input logic [31:0] addr, input logic wr,
                           input logic [31:0] wdata, input logic [3:0] wstrb, input logic pulse_done,
                           output logic [31:0] rdata, output logic err);
        int cyc;
        cyc = 0;
        @(posedge clk); #1;
        req.addr  = addr;
        req.write = wr;
        req.wdata = wdata;
        req.wstrb = wstrb;
        req.valid = 1'b1;
        if (pulse_done) done_i = 1'b1;
        do begin
            @(posedge clk); #1;
            done_i = 1'b0;
            cyc++;
        end while (!rsp.ready && cyc < 4);
        if (!rsp.ready) check({tag, " ready timeout"}, 64'd0, 64'd1);
        rdata     = rsp.rdata;
        err       = rsp.error;
        last_lat  = cyc;
        req.valid = 1'b0;
    endtask

    task automatic wr_ok(input string tag, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        logic [31:0] r;
        logic        e;
        bus_acc(tag, addr, 1'b1, wdata, wstrb, 1'b0, r, e);
        check({tag, " err"}, 64'(e), 64'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        logic        e;
        bus_acc(tag, addr, 1'b0, 32'h0, 4'h0, 1'b0, r, e);
        check({tag, " err"}, 64'(e), 64'd0);
        check({tag, " rdata"}, 64'(r), 64'(exp));
    endtask

    task automatic pulse_done;
        done_i = 1'b1;
        @(posedge clk); #1;
        done_i = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        req    = '0;
        done_i = 1'b0;
        err_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 64'(rsp.ready), 64'd0);
        check("reset error", 64'(rsp.error), 64'd0);
        check("reset start", 64'(start_o), 64'd0);
        check("reset busy", 64'(busy_o), 64'd0);
        check("reset irq", 64'(irq_o), 64'd0);
        check("reset cfg", 64'(|cfg_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        bus_acc("status0", 32'h4, 1'b0, 32'h0, 4'h0, 1'b0, rd, er);
        check("status0 latency", 64'(last_lat), 64'd1);
        check("status0 rdata", 64'(rd), 64'd0);
        check("status0 err", 64'(er), 64'd0);
        @(posedge clk); #1;
        check("ready one cycle", 64'(rsp.ready), 64'd0);

        // Strobe 0101 takes bytes 0 and 2 of the new word.
        wr_ok("cfg3 full", 32'd20, 32'h11223344, 4'hF);
        wr_ok("cfg3 strb", 32'd20, 32'hDEADBEEF, 4'b0101);
        cfg3_exp = 32'h11AD33EF;
        rd_chk("cfg3 rb", 32'd20, cfg3_exp);
        check("cfg_o[3]", 64'(cfg_o[3*32 +: 32]), 64'(cfg3_exp));
        check("cfg_o[0]", 64'(cfg_o[0 +: 32]), 64'd0);

        wr_ok("start", 32'h0, 32'h1, 4'hF);
        check("start_o pulse", 64'(start_o), 64'd1);
        check("busy after start", 64'(busy_o), 64'd1);
        @(posedge clk); #1;
        check("start_o drop", 64'(start_o), 64'd0);
        rd_chk("status busy", 32'h4, 32'h1);

        bus_acc("cfg busy", 32'd20, 1'b1, 32'h0, 4'hF, 1'b0, rd, er);
        check("cfg busy err", 64'(er), 64'd1);
        check("cfg busy rdata", 64'(rd), 64'd0);
        rd_chk("cfg3 unchanged", 32'd20, cfg3_exp);
        bus_acc("clear busy", 32'h0, 1'b1, 32'h2, 4'hF, 1'b0, rd, er);
        check("clear busy err", 64'(er), 64'd1);
        bus_acc("start busy", 32'h0, 1'b1, 32'h1, 4'hF, 1'b0, rd, er);
        check("start busy err", 64'(er), 64'd1);
        check("no restart pulse", 64'(start_o), 64'd0);

        pulse_done();
        check("busy after done", 64'(busy_o), 64'd0);
        rd_chk("status done", 32'h4, 32'h2);
        wr_ok("w1c done", 32'h4, 32'h2, 4'hF);
        rd_chk("status cleared", 32'h4, 32'h0);

        wr_ok("start2", 32'h0, 32'h1, 4'hF);
        rd_chk("status busy2", 32'h4, 32'h1);
        bus_acc("w1c+done", 32'h4, 1'b1, 32'h2, 4'hF, 1'b1, rd, er);
        check("w1c+done err", 64'(er), 64'd0);
        rd_chk("set wins", 32'h4, 32'h2);
        wr_ok("w1c done2", 32'h4, 32'h2, 4'hF);
        rd_chk("status cleared2", 32'h4, 32'h0);

        bus_acc("out of map", 32'd40, 1'b0, 32'h0, 4'h0, 1'b0, rd, er);
        check("out of map err", 64'(er), 64'd1);
        check("out of map rdata", 64'(rd), 64'd0);
        bus_acc("misaligned", 32'h2, 1'b0, 32'h0, 4'h0, 1'b0, rd, er);
        check("misaligned err", 64'(er), 64'd1);
        check("misaligned rdata", 64'(rd), 64'd0);
        bus_acc("oom write", 32'd40, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b0, rd, er);
        check("oom write err", 64'(er), 64'd1);
        check("cfg after errors", 64'(cfg_o[3*32 +: 32]), 64'(cfg3_exp));
        rd_chk("status after errors", 32'h4, 32'h0);

        err_i = 1'b1;
        @(posedge clk); #1;
        err_i = 1'b0;
        check("busy after err", 64'(busy_o), 64'd0);
        rd_chk("status err", 32'h4, 32'h4);
        wr_ok("w1c err busybit", 32'h4, 32'h5, 4'hF);
        rd_chk("status err clr", 32'h4, 32'h0);

        wr_ok("irq start", 32'h0, 32'h5, 4'hF);
        pulse_done();
        @(posedge clk); #1;
`ifdef CONV1D_REG_IRQ_EN
        check("irq set", 64'(irq_o), 64'd1);
        rd_chk("ctrl irq_en", 32'h0, 32'h4);
        wr_ok("irq w1c", 32'h4, 32'h2, 4'hF);
        @(posedge clk); #1;
        check("irq clr", 64'(irq_o), 64'd0);
`else
        check("irq tied", 64'(irq_o), 64'd0);
        rd_chk("ctrl irq_en ro", 32'h0, 32'h0);
        wr_ok("irq w1c", 32'h4, 32'h2, 4'hF);
        @(posedge clk); #1;
        check("irq tied2", 64'(irq_o), 64'd0);
`endif

        wr_ok("cfg0", 32'd8, 32'hA5A5A5A5, 4'hF);
        wr_ok("clear", 32'h0, 32'h2, 4'hF);
        check("clear cfg_o", 64'(|cfg_o), 64'd0);
        check("clear no start", 64'(busy_o), 64'd0);
        rd_chk("cfg3 cleared", 32'd20, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
